// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU between ID/EX and EX/MEM.
// Registered result/zero/overflow on a valid/ready stream.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 4)
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   alu_ctrl/src_a/src_b valid this cycle
//   in_ready   unit accepts an op this cycle
//   alu_ctrl   0000 AND, 0001 OR, 0010 ADD, 0110 SUB,
//              0111 SLT, 1100 NOR, 1000 MUL
//   src_a      operand A
//   src_b      operand B
//   out_valid  result/zero/overflow valid
//   out_ready  downstream takes the result this cycle
//   result     registered result
//   zero       result == 0
//   overflow   signed overflow (ADD/SUB only)
//   busy       multiply in progress
// Build option:
//   ALU_MULT_EN  adds a WIDTH-step shift-add multiplier for
//                code 1000. Without it, 1000 behaves as an
//                unknown code (result 0, zero 1, latency 1)
//                and busy is tied low.

module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
`ifdef ALU_MULT_EN
    localparam logic [3:0] ALU_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_drain;
    logic             w_is_mul;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    // ---------------- handshake ----------------
    // A new op may enter only when the output slot is
    // empty or is being emptied in this same cycle.
    assign in_ready = !reset
                    && (r_state == S_IDLE)
                    && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_valid && out_ready;

`ifdef ALU_MULT_EN
    assign w_is_mul = (alu_ctrl == ALU_MUL);
`else
    assign w_is_mul = 1'b0;
`endif

    // ---------------- single-cycle datapath ----------------
    assign w_sum  = src_a + src_b;
    assign w_diff = src_a - src_b;

    // Signed overflow: operands with matching (ADD) or
    // differing (SUB) signs giving a result whose sign
    // differs from src_a.
    assign w_ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1])
                    && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
    assign w_ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1])
                    && (w_diff[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (alu_ctrl)
            ALU_AND: w_alu_res = src_a & src_b;
            ALU_OR:  w_alu_res = src_a | src_b;
            ALU_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = w_ovf_add;
            end
            ALU_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = w_ovf_sub;
            end
            // Sign of the true difference, corrected
            // when the subtraction wrapped.
            ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                                  w_diff[WIDTH-1] ^ w_ovf_sub};
            ALU_NOR: w_alu_res = ~(src_a | src_b);
            default: begin
                w_alu_res = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    // ---------------- multiplier ----------------
`ifdef ALU_MULT_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;

    // Only the low WIDTH bits of the product are kept,
    // so the multiplicand may shift out of range freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (r_state == S_IDLE && w_accept && w_is_mul) begin
            r_cnt    <= '0;
            r_mcand  <= src_a;
            r_mplier <= src_b;
            r_prod   <= '0;
        end else if (r_state == S_MUL) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign busy = (r_state == S_MUL);
`else
    assign busy = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end
            end
`ifdef ALU_MULT_EN
            S_MUL: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output register ----------------
    // Load has priority over drain so an accept and a
    // drain in the same cycle replace the old result.
    // A multiply can only have been accepted with the slot
    // free, so DONE never overwrites an undrained result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_ovf       <= w_alu_ovf;
`ifdef ALU_MULT_EN
        end else if (r_state == S_DONE) begin
            r_out_valid <= 1'b1;
            r_result    <= r_prod;
            r_zero      <= (r_prod == '0);
            r_ovf       <= 1'b0;
`endif
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + randomized checks of
// alu_exec_unit against a plain-arithmetic reference model.

module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // expected {overflow, zero, result}, oldest first
    logic [33:0] sbq[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      s;
        logic [31:0] r;
        logic        o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = 32'd0;
        o  = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = sa + sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sa - sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
`ifdef ALU_MULT_EN
            4'b1000: r = a * b;
`endif
            default: r = 32'd0;
        endcase
        return {o, (r == 32'd0), r};
    endfunction

    function automatic int latency(input logic [3:0] c);
`ifdef ALU_MULT_EN
        if (c == 4'b1000) return W + 1;
`endif
        return 1;
    endfunction

    // Issue one op with out_ready held high, wait for its
    // result, check latency/value, then let it drain.
    task automatic run_op(input string tag,
                          input logic [3:0] c,
                          input logic [31:0] a,
                          input logic [31:0] b);
        int cyc;
        logic [33:0] e;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(c, a, b);
        cyc = 1;
`ifdef ALU_MULT_EN
        if (c == 4'b1000) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_stall"}, in_ready, 0);
        end
`endif
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, latency(c));
        chk({tag, "_out"}, {overflow, zero, result}, e);
        @(posedge clk);
        #1;
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    // One cycle with scoreboard: output compared to the
    // oldest expected entry every cycle it is valid.
    task automatic step(input bit v,
                        input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit ordy,
                        output bit acc);
        bit drn;
        @(negedge clk);
        in_valid  = v;
        alu_ctrl  = c;
        src_a     = a;
        src_b     = b;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid) begin
            if (sbq.size() == 0) chk("sb_spurious", out_valid, 0);
            else chk("sb_out", {overflow, zero, result}, sbq[0]);
        end
        drn = out_valid && ordy;
        @(posedge clk);
        if (drn && sbq.size() != 0) void'(sbq.pop_front());
        if (acc) sbq.push_back(model(c, a, b));
    endtask

    task automatic drain_all(input string tag);
        bit acc;
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin
            step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, acc);
            n++;
        end
        chk({tag, "_left"}, sbq.size(), 0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [3:0] rnd_code();
        logic [3:0] codes [9];
        codes[0] = 4'b0000;
        codes[1] = 4'b0001;
        codes[2] = 4'b0010;
        codes[3] = 4'b0110;
        codes[4] = 4'b0111;
        codes[5] = 4'b1100;
        codes[6] = 4'b0011;
        codes[7] = 4'b1111;
        codes[8] = 4'b1000;
        if ($urandom_range(0, 19) == 0) return codes[8];
        return codes[$urandom_range(0, 7)];
    endfunction

    initial begin
        bit acc;
        bit seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'b0000;
        src_a     = '0;
        src_b     = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", in_ready, 1);

        // directed ops
        run_op("add_5_7", 4'b0010, 32'd5, 32'd7);
        run_op("sub_ovf", 4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op("sub_eq", 4'b0110, 32'd9, 32'd9);
        run_op("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_max_min", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op("nor_0_0", 4'b1100, 32'd0, 32'd0);
        run_op("unk_0011", 4'b0011, 32'h1234, 32'h5678);
        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
        run_op("mul", 4'b1000, 32'd1234, 32'd5678);

        // backpressure: first result holds, no loss, order kept
        step(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, acc);
        chk("bp_acc_and", acc, 1);
        repeat (3) begin
            step(1'b1, 4'b0001, 32'h1000_0001, 32'h0000_0100, 1'b0, acc);
            chk("bp_stall", acc, 0);
        end
        step(1'b1, 4'b0001, 32'h1000_0001, 32'h0000_0100, 1'b1, acc);
        chk("bp_acc_or", acc, 1);
        step(1'b1, 4'b0010, 32'd100, 32'd23, 1'b1, acc);
        chk("bp_acc_add", acc, 1);
        drain_all("bp");

        // reset in the middle of a multiply drops it
        @(negedge clk);
        in_valid  = 1'b1;
        alu_ctrl  = 4'b1000;
        src_a     = 32'd1234;
        src_b     = 32'd5678;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_rdy", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_dropped", seen, 0);
        run_op("add_1_1", 4'b0010, 32'd1, 32'd1);

        // randomized stream with random backpressure
        sbq.delete();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, rnd_code(),
                 rnd_opnd(), rnd_opnd(),
                 $urandom_range(0, 3) != 0, acc);
        end
        drain_all("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
